// File: rtl/imem_loader_if.sv
// Stream-in and instruction-memory write bus of the program loader.
// The loader takes the slave side; the byte source / memory side takes the master side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a {count, 4*N data, xor checksum} frame,
// writes little-endian words into instruction memory and holds the core in reset until loaded.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  input  logic          start,
  output logic          core_rst,
  output logic          load_done,
  output logic          load_err
);

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t state, state_nxt;

  logic [15:0]           count, count_nxt;
  logic [16:0]           wcnt, wcnt_nxt;
  logic [1:0]            bsel, bsel_nxt;
  logic [23:0]           part, part_nxt;
  logic [7:0]            csum, csum_nxt;

  logic                  in_ready_q, in_ready_nxt;
  logic                  mem_we_q, mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_nxt;
  logic [31:0]           mem_wdata_q, mem_wdata_nxt;
  logic                  core_rst_q, core_rst_nxt;
  logic                  load_done_q, load_done_nxt;
  logic                  load_err_q, load_err_nxt;

  logic                  accept;
  logic [15:0]           hdr_n;
  logic                  last_word;

  assign accept    = bus.in_valid && in_ready_q;
  assign hdr_n     = {bus.in_data, count[7:0]};
  assign last_word = (bsel == 2'd3) && ((wcnt + 17'd1) == {1'b0, count});

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign core_rst      = core_rst_q;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HDR_LO;
      count       <= '0;
      wcnt        <= '0;
      bsel        <= '0;
      part        <= '0;
      csum        <= '0;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_rst_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      wcnt        <= wcnt_nxt;
      bsel        <= bsel_nxt;
      part        <= part_nxt;
      csum        <= csum_nxt;
      in_ready_q  <= in_ready_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      core_rst_q  <= core_rst_nxt;
      load_done_q <= load_done_nxt;
      load_err_q  <= load_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR_LO: if (accept) state_nxt = HDR_HI;
      HDR_HI: begin
        if (accept) begin
          if ({1'b0, hdr_n} > DEPTH)  state_nxt = ERR;
          else if (hdr_n == 16'd0)    state_nxt = CSUM;
          else                        state_nxt = DATA;
        end
      end
      DATA:   if (accept && last_word) state_nxt = CSUM;
      CSUM:   if (accept) state_nxt = (bus.in_data == csum) ? DONE : ERR;
      DONE,
      ERR:    if (start) state_nxt = HDR_LO;
      default: state_nxt = HDR_LO;
    endcase
  end

  always_comb begin
    count_nxt     = count;
    wcnt_nxt      = wcnt;
    bsel_nxt      = bsel;
    part_nxt      = part;
    csum_nxt      = csum;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
    case (state)
      HDR_LO: if (accept) count_nxt[7:0]  = bus.in_data;
      HDR_HI: if (accept) count_nxt[15:8] = bus.in_data;
      DATA: begin
        if (accept) begin
          csum_nxt = csum ^ bus.in_data;
          bsel_nxt = bsel + 2'd1;
          // Bytes enter at the top of part, so after three bytes it holds {b2,b1,b0}.
          if (bsel == 2'd3) begin
            mem_we_nxt    = 1'b1;
            mem_addr_nxt  = wcnt[ADDR_WIDTH-1:0];
            mem_wdata_nxt = {bus.in_data, part};
            wcnt_nxt      = wcnt + 17'd1;
          end else begin
            part_nxt = {bus.in_data, part[23:8]};
          end
        end
      end
      DONE,
      ERR: begin
        if (start) begin
          count_nxt = '0;
          wcnt_nxt  = '0;
          bsel_nxt  = '0;
          part_nxt  = '0;
          csum_nxt  = '0;
        end
      end
      default: ;
    endcase

    // Status flags are a function of the state being entered, so they flip on the same edge.
    in_ready_nxt  = !(state_nxt inside {DONE, ERR});
    core_rst_nxt  = (state_nxt != DONE);
    load_done_nxt = (state_nxt == DONE);
    load_err_nxt  = (state_nxt == ERR);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with ADDR_WIDTH=2: per-cycle vector table for the
// nominal load, then hand-written sequences for errors, gaps, boundaries, reload and reset.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic core_rst, load_done, load_err;

  imem_loader_if #(.ADDR_WIDTH(2)) bus ();

  imem_loader #(.ADDR_WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .start     (start),
    .core_rst  (core_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        st;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        rdy;
    logic        crst;
    logic        done;
    logic        err;
  } vec_t;

  vec_t       vt[14];
  int         total = 0;
  int         bad   = 0;
  logic [1:0]  wa[$];
  logic [31:0] wdq[$];
  logic [7:0]  strm[$];

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wdq.push_back(bus.mem_wdata);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_status(input string nm, input logic rdy, input logic crst,
                            input logic done, input logic err);
    chk({nm, ".status"}, {60'd0, bus.in_ready, core_rst, load_done, load_err},
        {60'd0, rdy, crst, done, err});
  endtask

  task automatic send_stream(input int gap);
    foreach (strm[i]) begin
      for (int g = 0; g < gap; g++) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = strm[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wa.delete();
    wdq.delete();
  endtask

  task automatic chk_nominal_writes(input string nm);
    chk({nm, ".nwr"},  wa.size(), 2);
    chk({nm, ".a0"},   wa[0],  0);
    chk({nm, ".d0"},   wdq[0], 32'h00500013);
    chk({nm, ".a1"},   wa[1],  1);
    chk({nm, ".d1"},   wdq[1], 32'h00100093);
  endtask

  initial begin
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;

    //        v     d      st    we    addr  wd              rdy   crst  done  err
    vt[0]  = '{1'b1, 8'h02, 1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 8'h13, 1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 8'h50, 1'b0, 1'b0, 2'd0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 32'h00500013,  1'b1, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 8'h93, 1'b0, 1'b0, 2'd0, 32'h00500013,  1'b1, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 32'h00500013,  1'b1, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 8'h10, 1'b0, 1'b0, 2'd0, 32'h00500013,  1'b1, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 8'h00, 1'b0, 1'b1, 2'd1, 32'h00100093,  1'b1, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b1, 8'hC0, 1'b0, 1'b0, 2'd1, 32'h00100093,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 32'h00100093,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[12] = '{1'b1, 8'h55, 1'b0, 1'b0, 2'd1, 32'h00100093,  1'b0, 1'b0, 1'b1, 1'b0};
    vt[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 32'h00100093,  1'b1, 1'b1, 1'b0, 1'b0};

    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 35'd0);
    chk_status("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // Nominal load, one table row per clock
    for (int i = 0; i < 14; i++) begin
      bus.in_valid = vt[i].v;
      bus.in_data  = vt[i].d;
      start        = vt[i].st;
      @(posedge clk); #1;
      chk($sformatf("row%0d", i),
          {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.in_ready, core_rst, load_done, load_err},
          {vt[i].we, vt[i].addr, vt[i].wd, vt[i].rdy, vt[i].crst, vt[i].done, vt[i].err});
    end
    start = 1'b0;
    chk("table.nwr", wa.size(), 2);

    // Reload after start: one-word image
    wa.delete();
    wdq.delete();
    strm = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_stream(0);
    idle(1);
    chk("reload.nwr", wa.size(), 1);
    chk("reload.a0", wa[0], 0);
    chk("reload.d0", wdq[0], 32'hEFBEADDE);
    chk_status("reload", 1'b0, 1'b0, 1'b1, 1'b0);

    // Checksum mismatch
    do_reset();
    strm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC1};
    send_stream(0);
    idle(2);
    chk_nominal_writes("csumerr");
    chk_status("csumerr", 1'b0, 1'b1, 1'b0, 1'b1);

    // Gapped nominal stream
    do_reset();
    strm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
    send_stream(3);
    idle(2);
    chk_nominal_writes("gap");
    chk_status("gap", 1'b0, 1'b0, 1'b1, 1'b0);

    // Empty image
    do_reset();
    strm = '{8'h00, 8'h00, 8'h00};
    send_stream(0);
    idle(2);
    chk("empty.nwr", wa.size(), 0);
    chk_status("empty", 1'b0, 1'b0, 1'b1, 1'b0);

    // Full-capacity image: 4 words, byte k of word i is {i,k}
    do_reset();
    strm = '{8'h04, 8'h00};
    x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = {i[3:0], k[3:0]};
        strm.push_back(b);
        x = x ^ b;
      end
    end
    strm.push_back(x);
    send_stream(0);
    idle(2);
    chk("full.nwr", wa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      w = {i[3:0], 4'd3, i[3:0], 4'd2, i[3:0], 4'd1, i[3:0], 4'd0};
      chk($sformatf("full.a%0d", i), wa[i], i);
      chk($sformatf("full.d%0d", i), wdq[i], w);
    end
    chk_status("full", 1'b0, 1'b0, 1'b1, 1'b0);

    // Over-capacity count
    do_reset();
    strm = '{8'h05, 8'h00};
    send_stream(0);
    chk_status("over", 1'b0, 1'b1, 1'b0, 1'b1);
    strm = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_stream(0);
    chk("over.nwr", wa.size(), 0);
    chk_status("over.hold", 1'b0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset after 6 data bytes
    do_reset();
    strm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00};
    send_stream(0);
    chk("midrst.pre", bus.mem_wdata, 32'h00500013);
    #2 rst = 1'b1;
    #1;
    chk("midrst.out", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 35'd0);
    chk_status("midrst", 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    wa.delete();
    wdq.delete();
    strm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
    send_stream(0);
    idle(1);
    chk_nominal_writes("afterrst");
    chk_status("afterrst", 1'b0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
